// File: rtl/hir_mem_pkg.sv
// hir_mem_pkg: shared collision-mode constants and controller state type for HIR memories
package hir_mem_pkg;
   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   typedef enum logic {CLEAR, READY} mem_state_t;
endpackage

// File: rtl/bram_sdp_be_bank.sv
// bram_sdp_be_bank: simple-dual-port byte-enabled RAM bank with registered read and selectable collision mode
// ports: clk/rst; write we, wr_be, wr_addr, wr_data; read re, rd_addr -> rd_data/rd_valid one cycle later
module bram_sdp_be_bank
   import hir_mem_pkg::*;
#(
   parameter int ADDR_WIDTH    = 10,
   parameter int ELEMENT_WIDTH = 16,
   parameter int WRITE_MODE    = WM_READ_FIRST
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ELEMENT_WIDTH/8-1:0] wr_be,
   input  logic [ADDR_WIDTH-1:0]      wr_addr,
   input  logic [ELEMENT_WIDTH-1:0]   wr_data,
   input  logic                       re,
   input  logic [ADDR_WIDTH-1:0]      rd_addr,
   output logic [ELEMENT_WIDTH-1:0]   rd_data,
   output logic                       rd_valid
);
   localparam int NBYTES = ELEMENT_WIDTH / 8;
   logic [ELEMENT_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [ELEMENT_WIDTH-1:0] old_word, new_word;
   assign old_word = mem[rd_addr];
   // write-first view: bytes being written this cycle to the same address override the stored ones
   always_comb begin
      new_word = old_word;
      for (int b = 0; b < NBYTES; b++)
         new_word[8*b +: 8] = (we && wr_be[b] && wr_addr == rd_addr) ? wr_data[8*b +: 8] : old_word[8*b +: 8];
   end
   always_ff @(posedge clk)
      for (int b = 0; b < NBYTES; b++)
         if (we && wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
   always_ff @(posedge clk)
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= re;
         if (re) rd_data <= (WRITE_MODE == WM_WRITE_FIRST) ? new_word : old_word;
      end
endmodule

// File: rtl/bram_mr1w_be.sv
// bram_mr1w_be: multi-read-port byte-enabled block RAM built from one bank per read port
// ports: clk/rst; per read port rd_addr_en, rd_addr_data, rd_en -> rd_data, rd_valid after RD_LATENCY;
//        write wr_addr_en, wr_addr_data, wr_en, wr_be, wr_data; init_busy while the clear sweep runs
module bram_mr1w_be
   import hir_mem_pkg::*;
#(
   parameter int                           ADDR_WIDTH     = 10,
   parameter int                           ELEMENT_WIDTH  = 16,
   parameter int                           NUM_RD         = 2,
   parameter int                           RD_LATENCY     = 1,
   parameter int                           WRITE_MODE     = WM_READ_FIRST,
   parameter int                           CLEAR_ON_RESET = 1,
   parameter logic [ELEMENT_WIDTH-1:0]     INIT_VALUE     = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_RD-1:0]                 rd_addr_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]      rd_addr_data,
   input  logic [NUM_RD-1:0]                 rd_en,
   output logic [NUM_RD*ELEMENT_WIDTH-1:0]   rd_data,
   output logic [NUM_RD-1:0]                 rd_valid,
   input  logic                              wr_addr_en,
   input  logic [ADDR_WIDTH-1:0]             wr_addr_data,
   input  logic                              wr_en,
   input  logic [ELEMENT_WIDTH/8-1:0]        wr_be,
   input  logic [ELEMENT_WIDTH-1:0]          wr_data,
   output logic                              init_busy
);
   localparam int NBYTES = ELEMENT_WIDTH / 8;
   mem_state_t state, state_nx;
   logic [ADDR_WIDTH-1:0]    clr_addr, bank_addr;
   logic [ELEMENT_WIDTH-1:0] bank_data;
   logic [NBYTES-1:0]        bank_be;
   logic                     busy, bank_we;
   logic [NUM_RD-1:0]        rd_issue;
   assign busy      = state == CLEAR;
   assign init_busy = busy;
   always_ff @(posedge clk)
      if (rst) begin
         state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         clr_addr <= '0;
      end else begin
         state    <= state_nx;
         clr_addr <= busy ? clr_addr + 1'b1 : clr_addr;
      end
   always_comb state_nx = (busy && &clr_addr) ? READY : state;
   // the sweep owns the write port while busy; nothing is written in a reset cycle
   assign bank_we   = ~rst & (busy | (wr_addr_en & wr_en & |wr_be));
   assign bank_be   = busy ? '1 : wr_be;
   assign bank_addr = busy ? clr_addr : wr_addr_data;
   assign bank_data = busy ? INIT_VALUE : wr_data;
   assign rd_issue  = rd_addr_en & rd_en & {NUM_RD{~busy}};
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ELEMENT_WIDTH-1:0] bd;
      logic                     bv;
      bram_sdp_be_bank #(
         .ADDR_WIDTH(ADDR_WIDTH),
         .ELEMENT_WIDTH(ELEMENT_WIDTH),
         .WRITE_MODE(WRITE_MODE)
      ) u_bank (
         .clk(clk),
         .rst(rst),
         .we(bank_we),
         .wr_be(bank_be),
         .wr_addr(bank_addr),
         .wr_data(bank_data),
         .re(rd_issue[i]),
         .rd_addr(rd_addr_data[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .rd_data(bd),
         .rd_valid(bv)
      );
      if (RD_LATENCY == 1) begin : g_direct
         assign rd_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = bd;
         assign rd_valid[i] = bv;
      end else begin : g_pipe
         logic [ELEMENT_WIDTH-1:0] pd [RD_LATENCY-1];
         logic [RD_LATENCY-2:0]    pv;
         always_ff @(posedge clk)
            if (rst) begin
               for (int k = 0; k < RD_LATENCY-1; k++) pd[k] <= '0;
               pv <= '0;
            end else begin
               pd[0] <= bd;
               pv[0] <= bv;
               for (int k = 1; k < RD_LATENCY-1; k++) begin
                  pd[k] <= pd[k-1];
                  pv[k] <= pv[k-1];
               end
            end
         assign rd_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = pd[RD_LATENCY-2];
         assign rd_valid[i] = pv[RD_LATENCY-2];
      end
   end
endmodule

// File: tb/tb_bram_mr1w_be.sv
// tb_bram_mr1w_be: directed bench for bram_mr1w_be, read-first and write-first instances against a behavioural model
module tb_bram_mr1w_be;
   localparam int AW = 4, EW = 16, NR = 3, L = 3;
   localparam logic [15:0] INIT = 16'hA5A5;
   logic clk = 1'b0, rst = 1'b1;
   logic [NR-1:0] rd_addr_en = '0, rd_en = '0;
   logic [NR*AW-1:0] rd_addr_data = '0;
   logic wr_addr_en = 1'b0, wr_en = 1'b0;
   logic [AW-1:0] wr_addr_data = '0;
   logic [1:0] wr_be = '0;
   logic [15:0] wr_data = '0;
   logic [NR*EW-1:0] rf_rd_data, wf_rd_data;
   logic [NR-1:0] rf_rd_valid, wf_rd_valid;
   logic rf_busy, wf_busy;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   bram_mr1w_be #(.ADDR_WIDTH(AW), .ELEMENT_WIDTH(EW), .NUM_RD(NR), .RD_LATENCY(L), .WRITE_MODE(0),
                  .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)) u_rf (
      .clk(clk), .rst(rst), .rd_addr_en(rd_addr_en), .rd_addr_data(rd_addr_data), .rd_en(rd_en),
      .rd_data(rf_rd_data), .rd_valid(rf_rd_valid), .wr_addr_en(wr_addr_en), .wr_addr_data(wr_addr_data),
      .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data), .init_busy(rf_busy));
   bram_mr1w_be #(.ADDR_WIDTH(AW), .ELEMENT_WIDTH(EW), .NUM_RD(NR), .RD_LATENCY(L), .WRITE_MODE(1),
                  .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)) u_wf (
      .clk(clk), .rst(rst), .rd_addr_en(rd_addr_en), .rd_addr_data(rd_addr_data), .rd_en(rd_en),
      .rd_data(wf_rd_data), .rd_valid(wf_rd_valid), .wr_addr_en(wr_addr_en), .wr_addr_data(wr_addr_data),
      .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data), .init_busy(wf_busy));

   typedef struct {int due; int port; logic [15:0] rf; logic [15:0] wf;} rd_t;
   rd_t pend[$];
   logic [15:0] m [16];
   logic [NR*EW-1:0] exp_rf = '0, exp_wf = '0;
   logic [NR-1:0] exp_v = '0;
   int busy_left = 0, edge_n = 0;
   bit started = 0;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic busy, wr_go;
      logic [3:0] a;
      logic [15:0] rf, wf;
      rd_t r;
      edge_n++;
      if (rst) begin
         started = 1;
         busy_left = 16;
         pend.delete();
         exp_v = '0; exp_rf = '0; exp_wf = '0;
      end else begin
         busy = busy_left > 0;
         wr_go = !busy && wr_addr_en && wr_en && (wr_be != 2'b00);
         if (!busy)
            for (int p = 0; p < NR; p++)
               if (rd_addr_en[p] && rd_en[p]) begin
                  a = rd_addr_data[p*AW +: AW];
                  rf = m[a];
                  wf = rf;
                  for (int b = 0; b < 2; b++)
                     if (wr_go && wr_be[b] && wr_addr_data == a) wf[8*b +: 8] = wr_data[8*b +: 8];
                  pend.push_back('{edge_n + L - 1, p, rf, wf});
               end
         if (wr_go)
            for (int b = 0; b < 2; b++)
               if (wr_be[b]) m[wr_addr_data][8*b +: 8] = wr_data[8*b +: 8];
         if (busy) begin
            m[16 - busy_left] = INIT;
            busy_left--;
         end
         exp_v = '0;
         while (pend.size() > 0 && pend[0].due == edge_n) begin
            r = pend.pop_front();
            exp_v[r.port] = 1'b1;
            exp_rf[r.port*EW +: EW] = r.rf;
            exp_wf[r.port*EW +: EW] = r.wf;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("rf_busy", rf_busy, busy_left > 0);
         chk("wf_busy", wf_busy, busy_left > 0);
         chk("rf_valid", rf_rd_valid, exp_v);
         chk("wf_valid", wf_rd_valid, exp_v);
         chk("rf_data", rf_rd_data, exp_rf);
         chk("wf_data", wf_rd_data, exp_wf);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic [3:0] a);
      rd_addr_en[p] = 1'b1;
      rd_en[p] = 1'b1;
      rd_addr_data[p*AW +: AW] = a;
   endtask

   task automatic clr_rd();
      rd_addr_en = '0;
      rd_en = '0;
   endtask

   task automatic set_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_addr_en = 1'b1; wr_en = 1'b1; wr_addr_data = a; wr_data = d; wr_be = be;
   endtask

   task automatic clr_wr();
      wr_addr_en = 1'b0; wr_en = 1'b0; wr_be = '0;
   endtask

   initial begin
      int n;
      tick();
      tick();
      rst = 1'b0;
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (rf_busy) n++;
      end
      chk("busy_len_first", n, 16);
      tick();
      for (int a = 0; a < 16; a++) begin
         set_rd(0, 4'(a)); set_rd(1, 4'(15 - a)); set_rd(2, 4'(a));
         tick();
      end
      clr_rd();
      repeat (4) tick();
      @(negedge clk);
      chk("hold_a5a5", rf_rd_data[15:0], 16'hA5A5);
      tick();
      set_wr(3, 16'h1234, 2'b11); tick();
      set_wr(3, 16'hFFEE, 2'b01); tick();
      set_wr(5, 16'hBEEF, 2'b10); tick();
      set_wr(7, 16'h0001, 2'b11); tick();
      clr_wr();
      chk("model_m3", m[3], 16'h12EE);
      chk("model_m5", m[5], 16'hBEA5);
      set_rd(0, 3); set_rd(1, 5); set_rd(2, 3);
      for (int j = 1; j <= 3; j++) begin
         @(posedge clk);
         #1;
         if (j == 1) clr_rd();
         @(negedge clk);
         chk("multi_valid", rf_rd_valid, (j == 3) ? 3'b111 : 3'b000);
         if (j == 3) chk("multi_data", rf_rd_data, 48'h12EE_BEA5_12EE);
      end
      tick();
      set_wr(7, 16'h00FF, 2'b11); set_rd(0, 7);
      tick();
      clr_wr(); clr_rd();
      tick(); tick();
      @(negedge clk);
      chk("coll_rf", rf_rd_data[15:0], 16'h0001);
      chk("coll_wf", wf_rd_data[15:0], 16'h00FF);
      tick();
      set_wr(3, 16'hAB00, 2'b10); set_rd(1, 3);
      tick();
      clr_wr(); clr_rd();
      tick(); tick();
      @(negedge clk);
      chk("coll_be_rf", rf_rd_data[31:16], 16'h12EE);
      chk("coll_be_wf", wf_rd_data[31:16], 16'hABEE);
      tick();
      set_rd(0, 3);
      tick();
      clr_rd();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         if (rf_rd_valid != 0 || wf_rd_valid != 0) n++;
         if (j == 1) chk("rst_rd_data", rf_rd_data, 48'h0);
         @(posedge clk);
         #1;
         if (j == 4) set_rd(1, 0);
         if (j == 5) clr_rd();
      end
      chk("rst_no_valid", n, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (rf_busy) n++;
         if (j == 12) set_wr(0, 16'h1111, 2'b11);
         if (j == 13) clr_wr();
      end
      chk("busy_len_restart", n, 16);
      tick();
      set_rd(0, 0); set_rd(2, 3);
      tick();
      clr_rd();
      tick(); tick();
      @(negedge clk);
      chk("sweep_wr_ignored", rf_rd_data[15:0], 16'hA5A5);
      chk("sweep_addr3", wf_rd_data[47:32], 16'hA5A5);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
